conv_tile_sched: RTL and testbench

Tile scheduler that sequences the conv_tile row-address generator across a full output feature map. It latches one layer's geometry (ix, iy, k, s, p) and derives the output extents with a sequential divider. It then issues output-tile origins (ox_start, oy_start) in raster order, one tile per tile_en pulse, waiting for tile_done between tiles. It sits between the layer-config front end and conv_tile / the PE array.

---
 rtl/conv_pkg.sv | 17 +
 rtl/seq_udiv.sv | 45 ++++
 rtl/conv_tile_sched.sv | 173 +++++++++++++++++
 tb/tb_conv_tile_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and constants for the conv tile scheduler and its divider.
package conv_pkg;

  localparam int CFG_W    = 4;
  localparam int DIV_CYC  = 17;
  localparam int DIV_W    = 17;
  localparam int SCHED_DW = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CALC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4
  } sched_state_e;

endpackage

// File: rtl/seq_udiv.sv
// 17-bit restoring divider by a CFG_W-bit divisor; one quotient bit per cycle.
module seq_udiv
  import conv_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [CFG_W-1:0] divisor,
  output logic             busy,
  output logic [DIV_W-1:0] quotient
);

  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] acc;
  logic [CFG_W-1:0] dvs;
  logic [4:0]       cnt;
  logic [DIV_W:0]   trial;
  logic [DIV_W:0]   diff;

  // acc shifts dividend bits out of the top while quotient bits enter at the bottom
  assign trial    = {rem, acc[DIV_W-1]};
  assign diff     = trial - (DIV_W+1)'(dvs);
  assign busy     = (cnt != 5'd0);
  assign quotient = acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem <= '0;
      acc <= '0;
      dvs <= '0;
      cnt <= '0;
    end else if (start && !busy) begin
      rem <= '0;
      acc <= dividend;
      dvs <= divisor;
      cnt <= 5'(DIV_CYC);
    end else if (busy) begin
      rem <= diff[DIV_W] ? trial[DIV_W-1:0] : diff[DIV_W-1:0];
      acc <= {acc[DIV_W-2:0], ~diff[DIV_W]};
      cnt <= cnt - 5'd1;
    end
  end

endmodule

// File: rtl/conv_tile_sched.sv
// Output-tile scheduler for conv_tile: derives output extents, then issues tile origins in raster order.
// Optional CONV_SCHED_PERF_EN adds saturating busy/stall cycle counters.
//
// state | meaning
// IDLE  | waiting for a valid layer start
// CALC  | dividers computing ox_total / oy_total
// ISSUE | presenting next tile, tile_en once stall_in drops
// WAIT  | tile in flight, waiting for tile_done
// DONE  | one-cycle done pulse
module conv_tile_sched
  import conv_pkg::*;
#(
  parameter int TILE_OX = 4,
  parameter int TILE_OY = 4,
  parameter int DW      = SCHED_DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DW-1:0]    ix,
  input  logic [DW-1:0]    iy,
  input  logic [CFG_W-1:0] k,
  input  logic [CFG_W-1:0] s,
  input  logic [CFG_W-1:0] p,
  input  logic             stall_in,
  input  logic             tile_done,
  output logic [DW-1:0]    ox_start,
  output logic [DW-1:0]    oy_start,
  output logic [7:0]       tile_ow,
  output logic [7:0]       tile_oh,
  output logic             tile_en,
  output logic             tile_stall,
  output logic [DW-1:0]    ox_total,
  output logic [DW-1:0]    oy_total,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
`ifdef CONV_SCHED_PERF_EN
  ,
  output logic [31:0]      perf_busy_cyc,
  output logic [31:0]      perf_stall_cyc
`endif
);

  sched_state_e     state, state_nxt;
  logic [DIV_W-1:0] ix_pad, iy_pad, num_x, num_y;
  logic [DIV_W-1:0] quo_x, quo_y;
  logic             busy_x, busy_y;
  logic             cfg_bad, accept, div_start, calc_done, tile_ack;
  logic [DW-1:0]    rem_x, rem_y;
  logic             last_col, last_row;

  assign ix_pad    = DIV_W'(ix) + DIV_W'({p, 1'b0});
  assign iy_pad    = DIV_W'(iy) + DIV_W'({p, 1'b0});
  assign num_x     = ix_pad - DIV_W'(k);
  assign num_y     = iy_pad - DIV_W'(k);
  assign cfg_bad   = (s == '0) || (ix_pad < DIV_W'(k)) || (iy_pad < DIV_W'(k));
  assign accept    = (state == ST_IDLE) && start;
  assign div_start = accept && !cfg_bad;
  assign calc_done = (state == ST_CALC) && !busy_x && !busy_y;
  assign tile_ack  = (state == ST_WAIT) && tile_done;

  seq_udiv u_div_x (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (num_x),
    .divisor  (s),
    .busy     (busy_x),
    .quotient (quo_x)
  );

  seq_udiv u_div_y (
    .clk      (clk),
    .reset    (reset),
    .start    (div_start),
    .dividend (num_y),
    .divisor  (s),
    .busy     (busy_y),
    .quotient (quo_y)
  );

  // remaining columns/rows from the origin to the map edge, inclusive
  assign rem_x    = ox_total - ox_start + DW'(1);
  assign rem_y    = oy_total - oy_start + DW'(1);
  assign tile_ow  = (rem_x >= DW'(TILE_OX)) ? 8'(TILE_OX) : rem_x[7:0];
  assign tile_oh  = (rem_y >= DW'(TILE_OY)) ? 8'(TILE_OY) : rem_y[7:0];
  assign last_col = ({1'b0, ox_start} + (DW+1)'(TILE_OX)) > {1'b0, ox_total};
  assign last_row = ({1'b0, oy_start} + (DW+1)'(TILE_OY)) > {1'b0, oy_total};

  assign busy       = (state != ST_IDLE);
  assign tile_stall = busy && stall_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tile_en   = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE:  if (div_start) state_nxt = ST_CALC;
      ST_CALC:  if (calc_done) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (!stall_in) begin
          tile_en   = 1'b1;
          state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (tile_done) state_nxt = (last_col && last_row) ? ST_DONE : ST_ISSUE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ox_start <= DW'(1);
      oy_start <= DW'(1);
      ox_total <= '0;
      oy_total <= '0;
      cfg_err  <= 1'b0;
    end else begin
      if (accept) begin
        cfg_err <= cfg_bad;
        if (!cfg_bad) begin
          ox_start <= DW'(1);
          oy_start <= DW'(1);
        end
      end
      if (calc_done) begin
        ox_total <= DW'(quo_x + DIV_W'(1));
        oy_total <= DW'(quo_y + DIV_W'(1));
        ox_start <= DW'(1);
        oy_start <= DW'(1);
      end
      // the final tile leaves the origin where it was so outputs hold after done
      if (tile_ack) begin
        if (!last_col) begin
          ox_start <= ox_start + DW'(TILE_OX);
        end else if (!last_row) begin
          ox_start <= DW'(1);
          oy_start <= oy_start + DW'(TILE_OY);
        end
      end
    end
  end

`ifdef CONV_SCHED_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else if (div_start) begin
      perf_busy_cyc  <= '0;
      perf_stall_cyc <= '0;
    end else begin
      if (busy && (perf_busy_cyc != '1))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
      if (tile_stall && (perf_stall_cyc != '1))
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_conv_tile_sched.sv
// Scoreboard bench for conv_tile_sched: expected tiles queued at start, monitor checks each tile_en.
module tb_conv_tile_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] ix = '0, iy = '0;
  logic [3:0]  k = '0, s = '0, p = '0;
  logic        stall_in = 1'b0;
  logic        tile_done = 1'b0;
  logic [15:0] ox_start, oy_start, ox_total, oy_total;
  logic [7:0]  tile_ow, tile_oh;
  logic        tile_en, tile_stall, busy, done, cfg_err;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  typedef struct {
    int ox;
    int oy;
    int ow;
    int oh;
  } tile_t;
  tile_t exp_q[$];

  conv_tile_sched #(.TILE_OX(4), .TILE_OY(4), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .ix         (ix),
    .iy         (iy),
    .k          (k),
    .s          (s),
    .p          (p),
    .stall_in   (stall_in),
    .tile_done  (tile_done),
    .ox_start   (ox_start),
    .oy_start   (oy_start),
    .tile_ow    (tile_ow),
    .tile_oh    (tile_oh),
    .tile_en    (tile_en),
    .tile_stall (tile_stall),
    .ox_total   (ox_total),
    .oy_total   (oy_total),
    .busy       (busy),
    .done       (done),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // monitor: every tile_en must match the head of the expected queue
  always @(negedge clk) begin
    if (!reset && tile_en) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_tile: got tile at (%0d,%0d) expected none", ox_start, oy_start);
      end else begin
        tile_t e;
        e = exp_q.pop_front();
        chk("tile_ox", int'(ox_start), e.ox);
        chk("tile_oy", int'(oy_start), e.oy);
        chk("tile_ow", int'(tile_ow), e.ow);
        chk("tile_oh", int'(tile_oh), e.oh);
      end
    end
  end

  always @(negedge clk) if (!reset && done) done_cnt++;

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ox_start"}, int'(ox_start), 1);
    chk({tag, "_oy_start"}, int'(oy_start), 1);
    chk({tag, "_tile_en"}, int'(tile_en), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_cfg_err"}, int'(cfg_err), 0);
    chk({tag, "_ox_total"}, int'(ox_total), 0);
    chk({tag, "_oy_total"}, int'(oy_total), 0);
    chk({tag, "_tile_ow"}, int'(tile_ow), 0);
    chk({tag, "_tile_oh"}, int'(tile_oh), 0);
    chk({tag, "_tile_stall"}, int'(tile_stall), 0);
  endtask

  // tot_x/tot_y are hand-computed extents; stall_tile/abort_tile < 0 disables that behaviour
  task automatic run_layer(input int ixv, input int iyv, input int kv, input int sv, input int pv,
                           input int tot_x, input int tot_y, input int stall_tile,
                           input int abort_tile, input bit spur);
    int ntiles = 0;
    int lat = 0;
    for (int oy = 1; oy <= tot_y; oy += 4) begin
      for (int ox = 1; ox <= tot_x; ox += 4) begin
        tile_t t;
        t.ox = ox;
        t.oy = oy;
        t.ow = (tot_x - ox + 1 >= 4) ? 4 : tot_x - ox + 1;
        t.oh = (tot_y - oy + 1 >= 4) ? 4 : tot_y - oy + 1;
        exp_q.push_back(t);
        ntiles++;
      end
    end

    @(posedge clk); #1;
    ix = 16'(ixv); iy = 16'(iyv); k = 4'(kv); s = 4'(sv); p = 4'(pv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (tile_en) begin
        lat = c;
        break;
      end
      if (spur && c == 5) begin
        tile_done = 1'b1;
        start = 1'b1;
      end else begin
        tile_done = 1'b0;
        start = 1'b0;
      end
    end
    tile_done = 1'b0;
    start = 1'b0;
    chk("first_tile_latency", lat, 18);
    chk("ox_total", int'(ox_total), tot_x);
    chk("oy_total", int'(oy_total), tot_y);
    chk("cfg_err_cleared", int'(cfg_err), 0);
    chk("busy_in_layer", int'(busy), 1);

    for (int t = 0; t < ntiles; t++) begin
      @(posedge clk); #1;
      if (t == abort_tile) begin
        reset = 1'b1;
        #1;
        check_reset_vals("abort");
        exp_q.delete();
        lat = done_cnt;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        repeat (4) @(posedge clk);
        chk("abort_no_done", done_cnt, lat);
        return;
      end
      if (spur && t == 1) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      tile_done = 1'b1;
      if (t == stall_tile) stall_in = 1'b1;
      @(posedge clk); #1;
      tile_done = 1'b0;
      if (t == ntiles - 1) begin
        @(negedge clk);
        chk("done_pulse", int'(done), 1);
        @(negedge clk);
        chk("done_after", int'(done), 0);
        chk("busy_after", int'(busy), 0);
        chk("tile_en_after", int'(tile_en), 0);
      end else begin
        if (t == stall_tile) begin
          for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall_hold_tile_en", int'(tile_en), 0);
            chk("tile_stall_mirror", int'(tile_stall), 1);
            @(posedge clk); #1;
            if (j == 2) stall_in = 1'b0;
          end
          @(negedge clk);
          chk("tile_stall_release", int'(tile_stall), 0);
        end else begin
          @(negedge clk);
        end
        chk("tile_en_next", int'(tile_en), 1);
      end
    end
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic cfg_err_case(input int ixv, input int kv, input int sv, input int pv,
                              input string tag);
    int en_seen = 0;
    @(posedge clk); #1;
    ix = 16'(ixv); iy = 16'(ixv); k = 4'(kv); s = 4'(sv); p = 4'(pv);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_cfg_err"}, int'(cfg_err), 1);
    chk({tag, "_busy"}, int'(busy), 0);
    repeat (25) begin
      @(negedge clk);
      if (tile_en || busy) en_seen++;
    end
    chk({tag, "_no_activity"}, en_seen, 0);
  endtask

  initial begin
    stall_in = 1'b1;
    #12;
    check_reset_vals("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_tile_stall", int'(tile_stall), 0);
    stall_in = 1'b0;

    run_layer(32, 32, 6, 2, 2, 16, 16, -1, -1, 1'b1);
    cfg_err_case(16, 3, 0, 1, "s_zero");
    cfg_err_case(4, 7, 1, 0, "k_too_big");
    run_layer(10, 10, 3, 1, 1, 10, 10, -1, -1, 1'b0);
    run_layer(20, 8, 5, 3, 1, 6, 2, 0, -1, 1'b0);
    run_layer(32, 32, 6, 2, 2, 16, 16, -1, 4, 1'b0);
    run_layer(10, 10, 3, 1, 1, 10, 10, 4, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
